fetch_unit: RTL

Instruction fetch front end for the 16-bit CPU, the consumer side of the program-memory interface. Drives the 12-bit `code_address` into the combinational program ROM, captures the returned 16-bit `instruction` together with its address into a small prefetch FIFO, and presents entries to the decoder over a valid/ready handshake. Sits between the program ROM and the decode stage, and accepts control-flow redirects from the execute stage.

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 78 +++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared CPU constants and the fetch entry bundle.
package fetch_unit_pkg;

  localparam int ADDR_W  = 12;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0] CPU_RESET_PC = 12'h000;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode valid/ready handshake.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instr_addr;
  logic               instr_ready;

  modport master (
    output instr_valid,
    output instr_data,
    output instr_addr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_data,
    input  instr_addr,
    output instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: flush, simultaneous push/pop, registered valid.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic         valid,
  output logic         full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nx;

  always_comb begin
    count_nx = count;
    unique case (1'b1)
      flush:                    count_nx = '0;
      !flush && push && !pop:   count_nx = count + CW'(1);
      !flush && !push && pop:   count_nx = count - CW'(1);
      default:                  count_nx = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      count <= count_nx;
      valid <= (count_nx != '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= wdata;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  assign head = mem[rd_ptr];
  assign full = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, prefetch FIFO, redirects.
// Optional FETCH_PERF_EN adds push and stall counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = CPU_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  code_address,
  input  logic [INSTR_W-1:0] instruction,
  fetch_unit_if.master       dec,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  logic [ADDR_W-1:0] pc;
  logic              push;
  logic              pop;
  logic              full;
  fetch_entry_t      wdata;
  fetch_entry_t      head;

  assign pop  = dec.instr_valid && dec.instr_ready;
  // A dequeue frees a slot in the same cycle, keeping 1/cycle throughput.
  assign push = !redirect_valid && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc <= RESET_PC;
    else if (redirect_valid)
      pc <= redirect_target;
    else if (push)
      pc <= pc + ADDR_W'(1);
  end

  assign code_address = pc;
  assign wdata.addr   = pc;
  assign wdata.data   = instruction;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .head  (head),
    .valid (dec.instr_valid),
    .full  (full)
  );

  assign dec.instr_data = head.data;
  assign dec.instr_addr = head.addr;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push)
        perf_fetched <= perf_fetched + 32'd1;
      if (dec.instr_valid && !dec.instr_ready)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
